// File: rtl/updi_break_gen.sv
`default_nettype none
// ============================================================================
// Module      : updi_break_gen
// Description : UPDI break generator; drives N low break pulses separated by
//               high gaps. Optional line-release check: UPDI_BREAK_RXCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module updi_break_gen #(
    parameter int BREAK_CLK   = 100000,
    parameter int GAP_CLK     = 1000,
    parameter int TIMEOUT_CLK = 100000,
    parameter int MAX_BREAKS  = 2,
    localparam int CNT_MAX_BG = (BREAK_CLK > GAP_CLK) ? BREAK_CLK : GAP_CLK,
    localparam int CNT_MAX    = (CNT_MAX_BG > TIMEOUT_CLK) ? CNT_MAX_BG : TIMEOUT_CLK,
    localparam int CNT_W      = $clog2(CNT_MAX + 1),
    localparam int NB_W       = $clog2(MAX_BREAKS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NB_W-1:0] n_breaks,
    input  logic            abort,
    input  logic            rx,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            pulse
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BREAK   = 2'd1;
    localparam logic [1:0] S_GAP     = 2'd2;
`ifdef UPDI_BREAK_RXCHECK_EN
    localparam logic [1:0] S_RELEASE = 2'd3;
`endif

    localparam logic [CNT_W-1:0] C_BREAK_LOAD = CNT_W'(BREAK_CLK - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_CLK - 1);
    localparam logic [NB_W-1:0]  C_NB_MAX     = NB_W'(MAX_BREAKS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [NB_W-1:0]  nb_q,    nb_d;
    logic             done_q,  done_d;
    logic             error_q, error_d;
    logic             rx_s;

`ifdef UPDI_BREAK_RXCHECK_EN
    localparam logic [CNT_W-1:0] C_TIMEOUT_LOAD = CNT_W'(TIMEOUT_CLK - 1);

    logic rx_meta_q, rx_s_q;

    // Idle-high line: synchroniser resets to 1 so reset does not look like stuck-low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end
    assign rx_s = rx_s_q;
`else
    logic unused_rx;
    assign unused_rx = rx;
    assign rx_s      = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nb_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_breaks == '0)
                        nb_d = NB_W'(1);
                    else if (n_breaks > C_NB_MAX)
                        nb_d = C_NB_MAX;
                    else
                        nb_d = n_breaks;
                    cnt_d   = C_BREAK_LOAD;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (cnt_q == '0) begin
                    if (nb_q > NB_W'(1)) begin
                        nb_d    = nb_q - NB_W'(1);
                        cnt_d   = C_GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
`ifdef UPDI_BREAK_RXCHECK_EN
                        cnt_d   = C_TIMEOUT_LOAD;
                        state_d = S_RELEASE;
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    cnt_d   = C_BREAK_LOAD;
                    state_d = S_BREAK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UPDI_BREAK_RXCHECK_EN
            S_RELEASE: begin
                if (rx_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every other transition and suppresses completion.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
        end
    end

    // Output decode
    always_comb begin
        busy  = (state_q != S_IDLE);
        pulse = (state_q != S_BREAK);
        done  = done_q;
        error = error_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_updi_break_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_updi_break_gen
// Description : Directed self-checking bench for updi_break_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updi_break_gen;

    localparam int BREAK_CLK   = 8;
    localparam int GAP_CLK     = 4;
    localparam int TIMEOUT_CLK = 16;
    localparam int MAX_BREAKS  = 3;
    localparam int NB_W        = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NB_W-1:0] n_breaks;
    logic            abort;
    logic            rx;
    logic            busy;
    logic            done;
    logic            error;
    logic            pulse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    updi_break_gen #(
        .BREAK_CLK   (BREAK_CLK),
        .GAP_CLK     (GAP_CLK),
        .TIMEOUT_CLK (TIMEOUT_CLK),
        .MAX_BREAKS  (MAX_BREAKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_breaks (n_breaks),
        .abort    (abort),
        .rx       (rx),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .pulse    (pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outputs in cycle c (cycle 1 follows the start edge) for nb breaks.
    task automatic expect_at(input int c, input int nb, input logic rxv,
                             output logic p, output logic b, output logic d, output logic e);
        int last_low;
        int rel;
        last_low = nb * (BREAK_CLK + GAP_CLK) - GAP_CLK;
        p = !((c <= last_low) && (((c - 1) % (BREAK_CLK + GAP_CLK)) < BREAK_CLK));
`ifdef UPDI_BREAK_RXCHECK_EN
        rel = rxv ? 1 : TIMEOUT_CLK;
        b = (c <= last_low + rel);
        d = (c == last_low + rel + 1);
        e = d && !rxv;
`else
        rel = 0;
        b = (c <= last_low + rel);
        d = (c == last_low + rel + 1);
        e = 1'b0;
`endif
    endtask

    // Start a sequence at edge 0 and check every cycle; poke>0 re-pulses start
    // and flips n_breaks during that cycle.
    task automatic run_seq(input string name, input logic [NB_W-1:0] nb, input int enb,
                           input logic rxv, input int poke);
        int   last;
        logic p, b, d, e;
        rx = rxv;
        repeat (3) @(posedge clk);
        #1;
        start    = 1'b1;
        n_breaks = nb;
        @(posedge clk);
        #1;
        start = 1'b0;
        last  = enb * (BREAK_CLK + GAP_CLK) - GAP_CLK + TIMEOUT_CLK + 3;
        for (int c = 1; c <= last; c++) begin
            expect_at(c, enb, rxv, p, b, d, e);
            check($sformatf("%s pulse c%0d", name, c), 32'(pulse), 32'(p));
            check($sformatf("%s busy c%0d",  name, c), 32'(busy),  32'(b));
            check($sformatf("%s done c%0d",  name, c), 32'(done),  32'(d));
            check($sformatf("%s error c%0d", name, c), 32'(error), 32'(e));
            start = (c == poke);
            if (c == poke)
                n_breaks = n_breaks ^ 2'b01;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        rx       = 1'b1;
        n_breaks = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",  32'(busy),  32'd0);
        check("reset done",  32'(done),  32'd0);
        check("reset error", 32'(error), 32'd0);
        check("reset pulse", 32'(pulse), 32'd1);
        rst = 1'b0;

        run_seq("dbl",   NB_W'(2), 2, 1'b1, 0);
        run_seq("nb0",   NB_W'(0), 1, 1'b1, 0);
        run_seq("nb7",   NB_W'(7), 3, 1'b1, 0);
        run_seq("stuck", NB_W'(1), 1, 1'b0, 0);
        run_seq("poke",  NB_W'(2), 2, 1'b1, 3);

        // Abort during cycle 5, fresh start at edge 10
        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        n_breaks = NB_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("abort pre pulse c%0d", c), 32'(pulse), 32'd0);
            check($sformatf("abort pre busy c%0d",  c), 32'(busy),  32'd1);
            abort = (c == 5);
            @(posedge clk);
            #1;
        end
        abort = 1'b0;
        for (int c = 6; c <= 10; c++) begin
            check($sformatf("abort post busy c%0d",  c), 32'(busy),  32'd0);
            check($sformatf("abort post pulse c%0d", c), 32'(pulse), 32'd1);
            check($sformatf("abort post done c%0d",  c), 32'(done),  32'd0);
            check($sformatf("abort post error c%0d", c), 32'(error), 32'd0);
            start = (c == 10);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("restart pulse c11", 32'(pulse), 32'd0);
        check("restart busy c11",  32'(busy),  32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("reabort busy", 32'(busy), 32'd0);

        // Reset asserted during cycle 4
        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        n_breaks = NB_W'(2);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("rst pre pulse c%0d", c), 32'(pulse), 32'd0);
            rst = (c == 4);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check("rst c5 busy",  32'(busy),  32'd0);
        check("rst c5 done",  32'(done),  32'd0);
        check("rst c5 error", 32'(error), 32'd0);
        check("rst c5 pulse", 32'(pulse), 32'd1);
        @(posedge clk);
        #1;
        check("rst c6 busy",  32'(busy),  32'd0);
        check("rst c6 pulse", 32'(pulse), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
